// File: rtl/mb_pattern_generator_pkg.sv
// Shared definitions for the mainband pattern generator: control words, FSM
// encoding, LFSR taps, per-lane seeds and burst limits.
package mb_pattern_generator_pkg;

  localparam int LFSR_W = 23;

  localparam logic [1:0] CW_IDLE  = 2'b00;
  localparam logic [1:0] CW_CLEAR = 2'b01;
  localparam logic [1:0] CW_LFSR  = 2'b10;
  localparam logic [1:0] CW_NOP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEARED = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // x^23+x^21+x^16+x^8+x^5+x^2+1 -> state bits 22,20,15,7,4,1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 23'h508092;

  localparam logic [LFSR_W-1:0] LANE_SEED [0:15] = '{
    23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
    23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807,
    23'h2AAAAA, 23'h155555, 23'h3C3C3C, 23'h0F0F0F,
    23'h123456, 23'h654321, 23'h7ABCDE, 23'h000001
  };

  localparam logic [31:0] VALID_BEAT = 32'h0F0F0F0F;

  localparam logic [6:0] LAST_BEAT_1K = 7'd31;
  localparam logic [6:0] LAST_BEAT_4K = 7'd127;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

  function automatic logic [LFSR_W-1:0] lane_seed(input int lane);
    return LANE_SEED[lane[3:0]];
  endfunction

  function automatic logic [6:0] last_beat(input logic burst_4k);
    return burst_4k ? LAST_BEAT_4K : LAST_BEAT_1K;
  endfunction

endpackage

// File: rtl/mb_pattern_generator_lfsr_step32.sv
// Combinational 32-step advance of one lane LFSR; bit 0 of bits_out is the
// first serial bit produced.
module lfsr_step32
  import mb_pattern_generator_pkg::*;
(
  input  logic [LFSR_W-1:0] state_in,
  output logic [31:0]       bits_out,
  output logic [LFSR_W-1:0] state_out
);

  logic [LFSR_W-1:0] work_s;

  // Unrolled serial shifting: output bit 22, feed back into bit 0
  always_comb begin
    work_s   = state_in;
    bits_out = 32'h0;
    for (int i = 0; i < 32; i++) begin
      bits_out[i] = work_s[LFSR_W-1];
      work_s      = {work_s[LFSR_W-2:0], lfsr_feedback(work_s)};
    end
    state_out = work_s;
  end

endmodule

// File: rtl/mb_pattern_generator.sv
// Mainband point-test pattern generator: per-lane PRBS23 data bursts or a
// fixed valid-lane pattern, sequenced by the point-test control word.
module mb_pattern_generator
  import mb_pattern_generator_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int BEAT_W    = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [1:0]                    i_cw,
  input  logic                          i_val_pattern_en,
  input  logic                          i_burst_count,
  output logic [NUM_LANES*BEAT_W-1:0]   o_lane_data,
  output logic [BEAT_W-1:0]             o_valid_lane,
  output logic                          o_data_valid,
  output logic                          o_pattern_finished,
  output logic                          o_busy
);

  state_t     state_r, state_nxt_s;
  logic       mode_data_r, mode_data_nxt_s;
  logic       burst_r, burst_nxt_s;
  logic [6:0] cnt_r, cnt_nxt_s;
  logic       emit_s, seed_load_s, lfsr_adv_s, run_req_s;

  logic [NUM_LANES*BEAT_W-1:0] lane_bits_s;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [LFSR_W-1:0] lfsr_r;
    logic [LFSR_W-1:0] lfsr_next_s;
    logic [31:0]       bits_s;

    lfsr_step32 u_step (
      .state_in  (lfsr_r),
      .bits_out  (bits_s),
      .state_out (lfsr_next_s)
    );

    // Lane LFSR advances only when a DATA beat is emitted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        lfsr_r <= lane_seed(g);
      end else if (seed_load_s) begin
        lfsr_r <= lane_seed(g);
      end else if (lfsr_adv_s) begin
        lfsr_r <= lfsr_next_s;
      end else begin
        lfsr_r <= lfsr_r;
      end
    end

    assign lane_bits_s[g*BEAT_W +: BEAT_W] = bits_s;
  end

  assign run_req_s = (i_cw == CW_LFSR) || i_val_pattern_en;

  // Next-state, beat emission and latch decisions; CLEAR_LFSR overrides all
  always_comb begin
    state_nxt_s     = state_r;
    mode_data_nxt_s = mode_data_r;
    burst_nxt_s     = burst_r;
    cnt_nxt_s       = cnt_r;
    emit_s          = 1'b0;
    seed_load_s     = 1'b0;
    if (i_cw == CW_CLEAR) begin
      state_nxt_s = ST_CLEARED;
      cnt_nxt_s   = 7'd0;
      seed_load_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_CLEARED: begin
          if (run_req_s) begin
            state_nxt_s     = ST_RUN;
            mode_data_nxt_s = (i_cw == CW_LFSR);
            burst_nxt_s     = i_burst_count;
            cnt_nxt_s       = 7'd0;
            emit_s          = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_RUN: begin
          // cnt_r is the index of the beat already on the outputs
          if (cnt_r == last_beat(burst_r)) begin
            state_nxt_s = ST_DONE;
          end else if (i_cw == CW_NOP) begin
            state_nxt_s = ST_RUN;
          end else if (run_req_s) begin
            emit_s    = 1'b1;
            cnt_nxt_s = cnt_r + 7'd1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DONE: begin
          if ((i_cw == CW_IDLE) && !i_val_pattern_en) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
    lfsr_adv_s = emit_s && mode_data_nxt_s;
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r            <= ST_IDLE;
      mode_data_r        <= 1'b0;
      burst_r            <= 1'b0;
      cnt_r              <= 7'd0;
      o_lane_data        <= '0;
      o_valid_lane       <= '0;
      o_data_valid       <= 1'b0;
      o_pattern_finished <= 1'b0;
      o_busy             <= 1'b0;
    end else begin
      state_r            <= state_nxt_s;
      mode_data_r        <= mode_data_nxt_s;
      burst_r            <= burst_nxt_s;
      cnt_r              <= cnt_nxt_s;
      o_lane_data        <= (emit_s && mode_data_nxt_s) ? lane_bits_s : '0;
      o_valid_lane       <= (emit_s && !mode_data_nxt_s) ? VALID_BEAT : '0;
      o_data_valid       <= emit_s;
      o_pattern_finished <= (state_r == ST_RUN) && (state_nxt_s == ST_DONE);
      o_busy             <= (state_nxt_s == ST_RUN);
    end
  end

endmodule

// File: tb/tb_mb_pattern_generator.sv
// Directed self-checking bench for mb_pattern_generator with an independent
// bit-serial PRBS23 reference for every lane.
module tb_mb_pattern_generator;
  import mb_pattern_generator_pkg::*;

  localparam int NL = 16;
  localparam int BW = 32;

  logic              clk;
  logic              rst_n;
  logic [1:0]        cw;
  logic              val_en;
  logic              burst;
  logic [NL*BW-1:0]  lane_data;
  logic [BW-1:0]     valid_lane;
  logic              dv, fin, busy;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [22:0]      g_st [NL];
  logic [NL*BW-1:0] exp_v;
  int               nvalid;

  mb_pattern_generator #(.NUM_LANES(NL), .BEAT_W(BW)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_cw               (cw),
    .i_val_pattern_en   (val_en),
    .i_burst_count      (burst),
    .o_lane_data        (lane_data),
    .o_valid_lane       (valid_lane),
    .o_data_valid       (dv),
    .o_pattern_finished (fin),
    .o_busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic g_seed();
    for (int l = 0; l < NL; l++) g_st[l] = LANE_SEED[l];
  endtask

  // Reference: serial out = bit 22, feedback = s22^s20^s15^s7^s4^s1 into bit 0
  task automatic g_beat(output logic [NL*BW-1:0] v);
    logic [22:0] s;
    logic        fb;
    v = '0;
    for (int l = 0; l < NL; l++) begin
      s = g_st[l];
      for (int b = 0; b < BW; b++) begin
        v[l*BW + b] = s[22];
        fb = s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1];
        s  = {s[21:0], fb};
      end
      g_st[l] = s;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cw = 2'b00; val_en = 1'b0; burst = 1'b0;
    #3;
    chk_cnt++;
    if ({dv, fin, busy} !== 3'b000 || lane_data !== '0 || valid_lane !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got dv/fin/busy=%b valid_lane=%h expected 000 and zero", {dv, fin, busy}, valid_lane);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if ({dv, fin, busy} !== 3'b000 || lane_data !== '0) begin
      err_cnt++;
      $display("FAIL reset_release_idle: got dv/fin/busy=%b expected 000", {dv, fin, busy});
    end
  endtask

  task automatic test_data_4k();
    cw = 2'b01; tick();
    chk_cnt++;
    if ({dv, fin, busy} !== 3'b000) begin
      err_cnt++;
      $display("FAIL clear_state: got dv/fin/busy=%b expected 000", {dv, fin, busy});
    end
    g_seed();
    burst = 1'b1; cw = 2'b10; tick();
    nvalid = 0;
    for (int k = 0; k < 128; k++) begin
      g_beat(exp_v);
      if (dv === 1'b1) nvalid++;
      chk_cnt++;
      if ({dv, fin, busy} !== 3'b101) begin
        err_cnt++;
        $display("FAIL data4k_ctrl beat %0d: got dv/fin/busy=%b expected 101", k, {dv, fin, busy});
      end
      chk_cnt++;
      if (lane_data !== exp_v || valid_lane !== 32'h0) begin
        err_cnt++;
        $display("FAIL data4k_lanes beat %0d: got %h vl=%h expected %h vl=0", k, lane_data, valid_lane, exp_v);
      end
      tick();
    end
    chk_cnt++;
    if ({dv, fin, busy} !== 3'b010 || nvalid !== 128) begin
      err_cnt++;
      $display("FAIL data4k_finish: got dv/fin/busy=%b beats=%0d expected 010 beats=128", {dv, fin, busy}, nvalid);
    end
    tick();
    chk_cnt++;
    if ({dv, fin, busy} !== 3'b000 || lane_data !== '0) begin
      err_cnt++;
      $display("FAIL done_ignores_run: got dv/fin/busy=%b expected 000", {dv, fin, busy});
    end
    cw = 2'b00; tick();
  endtask

  task automatic test_valid_1k();
    cw = 2'b00; val_en = 1'b1; burst = 1'b0; tick();
    for (int k = 0; k < 32; k++) begin
      chk_cnt++;
      if ({dv, fin, busy} !== 3'b101 || valid_lane !== 32'h0F0F0F0F || lane_data !== '0) begin
        err_cnt++;
        $display("FAIL valid1k beat %0d: got dv/fin/busy=%b vl=%h expected 101 vl=0f0f0f0f data=0", k, {dv, fin, busy}, valid_lane);
      end
      tick();
    end
    chk_cnt++;
    if ({dv, fin, busy} !== 3'b010 || valid_lane !== 32'h0) begin
      err_cnt++;
      $display("FAIL valid1k_finish: got dv/fin/busy=%b vl=%h expected 010 vl=0", {dv, fin, busy}, valid_lane);
    end
    val_en = 1'b0; tick();
    chk_cnt++;
    if ({dv, fin, busy} !== 3'b000) begin
      err_cnt++;
      $display("FAIL valid1k_exit: got dv/fin/busy=%b expected 000", {dv, fin, busy});
    end
  endtask

  task automatic test_nop();
    cw = 2'b01; tick();
    g_seed();
    burst = 1'b1; cw = 2'b10; tick();
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      g_beat(exp_v);
      if (dv === 1'b1) nvalid++;
      chk_cnt++;
      if (lane_data !== exp_v) begin
        err_cnt++;
        $display("FAIL nop_pre beat %0d: got %h expected %h", k, lane_data, exp_v);
      end
      if (k < 9) tick();
    end
    cw = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cnt++;
      if ({dv, fin, busy} !== 3'b001 || lane_data !== '0) begin
        err_cnt++;
        $display("FAIL nop_freeze cycle %0d: got dv/fin/busy=%b expected 001 data=0", i, {dv, fin, busy});
      end
    end
    cw = 2'b10; tick();
    for (int k = 10; k < 128; k++) begin
      g_beat(exp_v);
      if (dv === 1'b1) nvalid++;
      chk_cnt++;
      if (lane_data !== exp_v || dv !== 1'b1) begin
        err_cnt++;
        $display("FAIL nop_post beat %0d: got dv=%b %h expected dv=1 %h", k, dv, lane_data, exp_v);
      end
      tick();
    end
    chk_cnt++;
    if (fin !== 1'b1 || nvalid !== 128) begin
      err_cnt++;
      $display("FAIL nop_total: got fin=%b beats=%0d expected fin=1 beats=128", fin, nvalid);
    end
    cw = 2'b00; tick();
  endtask

  task automatic test_abort();
    cw = 2'b01; tick();
    g_seed();
    burst = 1'b1; cw = 2'b10; tick();
    for (int k = 0; k <= 50; k++) begin
      g_beat(exp_v);
      chk_cnt++;
      if (lane_data !== exp_v || dv !== 1'b1) begin
        err_cnt++;
        $display("FAIL abort_pre beat %0d: got dv=%b %h expected dv=1 %h", k, dv, lane_data, exp_v);
      end
      if (k < 50) tick();
    end
    cw = 2'b00; tick();
    chk_cnt++;
    if ({dv, fin, busy} !== 3'b000 || lane_data !== '0) begin
      err_cnt++;
      $display("FAIL abort_stop: got dv/fin/busy=%b expected 000", {dv, fin, busy});
    end
    tick();
    chk_cnt++;
    if (fin !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_no_finish: got fin=%b busy=%b expected 0 0", fin, busy);
    end
    // no clear: the next run continues from the retained LFSR state
    cw = 2'b10; tick();
    g_beat(exp_v);
    chk_cnt++;
    if (lane_data !== exp_v || dv !== 1'b1) begin
      err_cnt++;
      $display("FAIL resume_no_clear: got dv=%b %h expected dv=1 %h", dv, lane_data, exp_v);
    end
    cw = 2'b00; tick();
  endtask

  task automatic test_mode_priority();
    cw = 2'b01; tick();
    g_seed();
    burst = 1'b0; cw = 2'b10; val_en = 1'b1; tick();
    g_beat(exp_v);
    chk_cnt++;
    if (lane_data !== exp_v || valid_lane !== 32'h0) begin
      err_cnt++;
      $display("FAIL both_req_data_wins: got vl=%h %h expected vl=0 %h", valid_lane, lane_data, exp_v);
    end
    cw = 2'b00; tick();
    g_beat(exp_v);
    chk_cnt++;
    if (lane_data !== exp_v || valid_lane !== 32'h0 || dv !== 1'b1) begin
      err_cnt++;
      $display("FAIL mode_stays_data: got dv=%b vl=%h %h expected dv=1 vl=0 %h", dv, valid_lane, lane_data, exp_v);
    end
    val_en = 1'b0; tick();
  endtask

  task automatic test_clear_mid();
    cw = 2'b01; tick();
    g_seed();
    burst = 1'b1; cw = 2'b10; tick();
    for (int k = 0; k <= 20; k++) begin
      g_beat(exp_v);
      chk_cnt++;
      if (lane_data !== exp_v) begin
        err_cnt++;
        $display("FAIL clear_mid_pre beat %0d: got %h expected %h", k, lane_data, exp_v);
      end
      if (k < 20) tick();
    end
    cw = 2'b01; tick();
    chk_cnt++;
    if ({dv, fin, busy} !== 3'b000 || lane_data !== '0) begin
      err_cnt++;
      $display("FAIL clear_mid_stop: got dv/fin/busy=%b expected 000", {dv, fin, busy});
    end
    g_seed();
    cw = 2'b10; tick();
    for (int k = 0; k < 3; k++) begin
      g_beat(exp_v);
      chk_cnt++;
      if (lane_data !== exp_v || dv !== 1'b1) begin
        err_cnt++;
        $display("FAIL clear_mid_restart beat %0d: got dv=%b %h expected dv=1 %h", k, dv, lane_data, exp_v);
      end
      tick();
    end
    cw = 2'b00; tick();
  endtask

  task automatic test_reset_mid();
    cw = 2'b01; tick();
    g_seed();
    burst = 1'b1; cw = 2'b10; tick();
    for (int k = 0; k <= 60; k++) begin
      g_beat(exp_v);
      chk_cnt++;
      if (lane_data !== exp_v) begin
        err_cnt++;
        $display("FAIL reset_mid_pre beat %0d: got %h expected %h", k, lane_data, exp_v);
      end
      if (k < 60) tick();
    end
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({dv, fin, busy} !== 3'b000 || lane_data !== '0 || valid_lane !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_mid_immediate: got dv/fin/busy=%b expected 000 and zero data", {dv, fin, busy});
    end
    cw = 2'b00;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if ({dv, fin, busy} !== 3'b000 || lane_data !== '0) begin
        err_cnt++;
        $display("FAIL reset_mid_quiet cycle %0d: got dv/fin/busy=%b expected 000", i, {dv, fin, busy});
      end
    end
    g_seed();
    cw = 2'b10; tick();
    g_beat(exp_v);
    chk_cnt++;
    if (lane_data !== exp_v || dv !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_reseeds: got dv=%b %h expected dv=1 %h", dv, lane_data, exp_v);
    end
    cw = 2'b00; tick();
  endtask

  initial begin
    test_reset();
    test_data_4k();
    test_valid_1k();
    test_nop();
    test_abort();
    test_mode_priority();
    test_clear_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
